mem_burst_master: RTL and testbench

- Initiator for the single-port synchronous RAM interface: address, write data, write enable, read data.
- The RAM registers the address on each clock edge and returns read data one cycle later.
- This block accepts read or write burst commands on a valid/ready command port and streams write data in.
- It drives the RAM port one beat per cycle and returns read data on a valid/ready response port through a 2-entry buffer.
- It sits between a host or DMA-side controller and the memory.

---
 rtl/mem_burst_master.sv | 159 +++++++++++++++
 tb/tb_mem_burst_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Burst initiator for a single-port synchronous RAM (address registered on
//   the clock edge, read data returned one cycle later). It accepts read or
//   write burst commands, streams write beats straight onto the RAM port, and
//   returns read beats through a 2-entry response FIFO.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (accepted only in IDLE)
//   cmd_we, cmd_adr, cmd_len      burst direction, start address, beats-1
//   wr_valid/wr_ready, wr_data    write beat stream
//   rsp_valid/rsp_ready           read response handshake
//   rsp_data, rsp_last            read data and final-beat marker
//   busy                          burst active, read in flight or data buffered
//   mem_adr, mem_we, mem_dat_w    RAM request side
//   mem_dat_r                     RAM read data (one cycle after the address)
module mem_burst_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dat_w,
  input  logic [DATA_W-1:0] mem_dat_r
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rsp_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, adr_hold;
  logic [LEN_W-1:0]  cnt, len;
  logic              inflight, inflight_last;
  rsp_t              fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic              pop, push, issue, wr_beat, beat, at_last, cmd_fire;
  rsp_t              head;

  assign at_last  = (cnt == len);
  assign cmd_fire = cmd_valid & cmd_ready;
  assign pop      = rsp_valid & rsp_ready;
  // Data requested last cycle is on mem_dat_r now; capture it.
  assign push     = inflight;

  // Occupancy counts the buffered entries plus the beat on its way back, so
  // a read is only issued when its data is guaranteed a FIFO slot.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue    = (state == READ) && (occ < 3'd2);
  assign wr_beat  = (state == WRITE) && wr_valid;
  assign beat     = issue | wr_beat;

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_we ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && at_last) state_nxt = IDLE;
      end
      READ: begin
        if (issue && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Burst address / beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
      len  <= '0;
    end else if (cmd_fire) begin
      addr <= cmd_adr;
      len  <= cmd_len;
      cnt  <= '0;
    end else if (beat) begin
      addr <= addr + 1'b1;
      if (!at_last) cnt <= cnt + 1'b1;
    end
  end

  // RAM port: the address follows the burst while writing or issuing a read,
  // otherwise it holds the last value driven so the RAM sees no new request.
  assign mem_adr   = ((state == WRITE) || issue) ? addr : adr_hold;
  assign mem_we    = wr_beat;
  assign mem_dat_w = (state == WRITE) ? wr_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_hold      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      adr_hold      <= mem_adr;
      inflight      <= issue;
      inflight_last <= issue & at_last;
    end
  end

  // Response FIFO pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{last: inflight_last, data: mem_dat_r};
  end

  assign head      = fifo_mem[rd_ptr];
  assign rsp_valid = (fifo_cnt != 2'd0);
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_last  = rsp_valid & head.last;

  assign busy = (state != IDLE) | inflight | (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [3:0] cmd_adr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rsp_valid, rsp_ready, rsp_last, busy;
  logic [7:0] rsp_data;
  logic [3:0] mem_adr;
  logic       mem_we;
  logic [7:0] mem_dat_w, mem_dat_r;

  always #5 clk = ~clk;

  mem_burst_master #(.ADDR_W(4), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat_w(mem_dat_w),
    .mem_dat_r(mem_dat_r)
  );

  // Synchronous RAM: address sampled on the edge, data out one cycle later.
  logic [7:0] ram [16];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_dat_w;
    ram_q <= ram[mem_adr];
  end
  assign mem_dat_r = ram_q;

  // Reference model: expected memory contents plus queues of expected
  // RAM writes {adr,data} and responses {last,data}, in order.
  logic [7:0]  ref_mem [16];
  logic [11:0] exp_wr [$];
  logic [8:0]  exp_rsp [$];
  logic [7:0]  wdat [16];
  int          n_chk = 0, n_fail = 0;
  int          wcount = 0, rcount = 0;
  int          rsp_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard on the falling edge: what is seen here is what the next
  // rising edge will commit.
  always @(negedge clk) begin
    logic [11:0] ew;
    logic [8:0]  er;
    if (!rst) begin
      if (mem_we) begin
        wcount++;
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          ew = exp_wr.pop_front();
          chk("wr_adr", mem_adr, ew[11:8]);
          chk("wr_dat", mem_dat_w, ew[7:0]);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rcount++;
        chk("rsp_expected", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          er = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, er[7:0]);
          chk("rsp_last", rsp_last, er[8]);
        end
      end
    end
  end

  // Response back-pressure driver
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_cmd(input logic we, input logic [3:0] adr, input logic [3:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // gap: 0 = wr_valid always high, 1 = toggling 1,0,1,..., 2 = random
  task automatic wr_burst(input logic [3:0] adr, input logic [3:0] len, input int gap,
                          output int cycles);
    int i = 0, n = 0;
    logic [3:0] a;
    for (int k = 0; k <= int'(len); k++) begin
      a = adr + 4'(k);
      exp_wr.push_back({a, wdat[k]});
      ref_mem[a] = wdat[k];
    end
    send_cmd(1'b1, adr, len);
    while (i <= int'(len) && n < 400) begin
      case (gap)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (n % 2 == 0);
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      wr_data = wdat[i];
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      @(posedge clk); #1;
      n++;
    end
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    chk("wr_beats", i, int'(len) + 1);
    cycles = n;
  endtask

  task automatic rd_burst(input logic [3:0] adr, input logic [3:0] len);
    logic [3:0] a;
    for (int k = 0; k <= int'(len); k++) begin
      a = adr + 4'(k);
      exp_rsp.push_back({k == int'(len), ref_mem[a]});
    end
    send_cmd(1'b0, adr, len);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 1000) begin
      @(negedge clk); n++;
    end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_rsp_q"}, exp_rsp.size(), 0);
    chk({tag, "_wr_q"}, exp_wr.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, w0, r0;
    logic [6:0] vpat;
    logic [3:0] ra, rl;
    rst = 1'b1;
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0;
    for (int k = 0; k < 16; k++) begin ram[k] = 8'h00; ref_mem[k] = 8'h00; end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_dat_w", mem_dat_w, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write burst at 0xE, 4 beats, wrapping E,F,0,1
    wdat[0] = 8'hA1; wdat[1] = 8'hA2; wdat[2] = 8'hA3; wdat[3] = 8'hA4;
    wr_burst(4'hE, 4'd3, 0, cyc);
    chk("wr4_cycles", cyc, 4);
    chk("wr4_cmd_ready_after", cmd_ready, 1);
    drain("wr4");

    // Read it back with rsp_ready high: rsp_valid on cycles 3..6 after accept
    rd_burst(4'hE, 4'd3);
    chk("rd4_first_adr", mem_adr, 4'hE);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vpat[k] = rsp_valid;
      if (k == 5) chk("rd4_busy_last_pop", busy, 1);
      if (k == 6) chk("rd4_busy_after", busy, 0);
      @(posedge clk); #1;
    end
    chk("rd4_valid_pattern", vpat, 7'b0111100);
    drain("rd4");

    // Read with rsp_ready held low for 5 cycles: two beats buffered, issue stops
    rsp_mode = 2; rsp_ready = 1'b0;
    r0 = rcount;
    rd_burst(4'hE, 4'd3);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("stall_adr_a", mem_adr, 4'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_adr_b", mem_adr, 4'hF);
    chk("stall_valid", rsp_valid, 1);
    chk("stall_head", rsp_data, 8'hA1);
    chk("stall_busy", busy, 1);
    chk("stall_no_pop", rcount, r0);
    @(posedge clk); #1;
    rsp_mode = 0; rsp_ready = 1'b1;
    drain("stall");
    chk("stall_count", rcount - r0, 4);

    // Single-beat write then read at 0x5
    w0 = wcount;
    wdat[0] = 8'h3C;
    wr_burst(4'h5, 4'd0, 0, cyc);
    drain("one_wr");
    chk("one_wr_pulses", wcount - w0, 1);
    r0 = rcount;
    rd_burst(4'h5, 4'd0);
    drain("one_rd");
    chk("one_rd_count", rcount - r0, 1);

    // Write burst with wr_valid toggling
    w0 = wcount;
    for (int k = 0; k < 4; k++) wdat[k] = 8'h50 + 8'(k);
    wr_burst(4'h8, 4'd3, 1, cyc);
    drain("toggle");
    chk("toggle_writes", wcount - w0, 4);
    chk("toggle_cycles", cyc, 7);

    // Reset during the 2nd beat of an 8-beat read
    rd_burst(4'h0, 4'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rsp.delete();
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_mem_we", mem_we, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_burst(4'hE, 4'd3);
    drain("post_rst");

    // Randomised traffic, back-to-back commands, random back-pressure
    for (int t = 0; t < 40; t++) begin
      ra = 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      rsp_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) wdat[k] = 8'($urandom);
        wr_burst(ra, rl, $urandom_range(0, 2), cyc);
      end else begin
        rd_burst(ra, rl);
      end
      if ($urandom_range(0, 3) == 0) begin
        rsp_mode = 0;
        drain("rand_mid");
      end
    end
    rsp_mode = 0;
    drain("rand_end");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
